// File: rtl/ioctl_upload_reader.sv
// ioctl_upload_reader
// ---------------------------------------------------------------------------
// Answers HPS upload read strobes (ioctl_rd) with 16-bit words fetched from
// the emulator memory bus through a req/ack handshake. A one-word prefetch
// buffer holds the word at the expected next address P, so sequential reads
// are served from the buffer. ioctl_wait is high while the word is not ready.
// A fetch with no ack after TIMEOUT cycles completes with FILL_WORD and sets
// the sticky upload_err flag.
//
// Ports:
//   clk_sys       system clock, rising edge
//   reset         asynchronous active-high reset
//   ioctl_upload  upload session active (level)
//   ioctl_rd      single-cycle read strobe from the HPS
//   ioctl_addr    byte address of the requested word (bit 0 ignored)
//   ioctl_din     word returned to the HPS
//   ioctl_wait    HPS stalls while high
//   mem_req       memory read request, held until ack or timeout
//   mem_addr      memory word address, stable while mem_req is high
//   mem_ack       single-cycle ack; mem_rdata valid in the same cycle
//   mem_rdata     memory read data
//   upload_err    sticky timeout flag for the current session
// ---------------------------------------------------------------------------
module ioctl_upload_reader #(
  parameter int          MEM_AW    = 23,
  parameter int          TIMEOUT   = 255,
  parameter logic [15:0] FILL_WORD = 16'hFFFF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [15:0]       ioctl_din,
  output logic              ioctl_wait,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              upload_err
);

  // The counter only needs to reach TIMEOUT-1: the fetch is abandoned in the
  // cycle where it would step onto TIMEOUT.
  localparam int            CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFETCH,
    ST_READY,
    ST_DEMAND,
    ST_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         din_q, din_d;
  logic                wait_q, wait_d;
  logic                req_q, req_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic                err_q, err_d;
  logic [15:0]         buf_q, buf_d;
  logic                buf_valid_q, buf_valid_d;
  logic [MEM_AW-1:0]   p_q, p_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                restart_q, restart_d;
  logic                upload_prev_q;

  logic                upload_rise;
  logic                restart_now;
  logic                timeout_hit;
  logic                fetch_done;
  logic [15:0]         fetch_data;
  logic [MEM_AW-1:0]   rd_word;

  assign upload_rise = ioctl_upload & ~upload_prev_q;
  // A restart seen during a drain stays pending only while upload stays high.
  assign restart_now = ioctl_upload & (restart_q | upload_rise);
  // An ack in the final cycle beats the timeout: real data, no error.
  assign timeout_hit = req_q & ~mem_ack & (cnt_q == CNT_LAST);
  assign fetch_done  = req_q & (mem_ack | timeout_hit);
  assign fetch_data  = mem_ack ? mem_rdata : FILL_WORD;
  assign rd_word     = ioctl_addr[MEM_AW:1];

  // Address bits outside the word address are deliberately ignored.
  generate
    if (MEM_AW < 24) begin : g_unused_hi
      logic unused_addr_bits;
      assign unused_addr_bits = ^{ioctl_addr[24:MEM_AW+1], ioctl_addr[0]};
    end else begin : g_unused_lo
      logic unused_addr_bits;
      assign unused_addr_bits = ioctl_addr[0];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    din_d       = din_q;
    wait_d      = wait_q;
    req_d       = req_q;
    addr_d      = addr_q;
    err_d       = err_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    p_d         = p_q;
    restart_d   = restart_q;
    // Every new request starts from a cycle with req low or a completed
    // fetch, so the counter is always zero when mem_req (re)starts.
    cnt_d       = (req_q && !fetch_done) ? cnt_q + CW'(1) : '0;

    if ((state_q inside {ST_PREFETCH, ST_READY, ST_DEMAND}) && !ioctl_upload) begin
      // Session ended: release the HPS at once. An outstanding fetch must
      // still be finished on the memory side, so it is drained.
      wait_d      = 1'b0;
      buf_valid_d = 1'b0;
      restart_d   = 1'b0;
      if (req_q && !fetch_done) begin
        state_d = ST_DRAIN;
      end else begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          restart_d = 1'b0;
          if (upload_rise) begin
            state_d     = ST_PREFETCH;
            p_d         = '0;
            addr_d      = '0;
            req_d       = 1'b1;
            wait_d      = 1'b1;
            err_d       = 1'b0;
            buf_valid_d = 1'b0;
          end
        end

        ST_PREFETCH: begin
          if (fetch_done) begin
            buf_d       = fetch_data;
            buf_valid_d = 1'b1;
            req_d       = 1'b0;
            wait_d      = 1'b0;
            if (timeout_hit) err_d = 1'b1;
            state_d     = ST_READY;
          end
        end

        ST_READY: begin
          if (ioctl_rd && !wait_q && buf_valid_q) begin
            req_d       = 1'b1;
            wait_d      = 1'b1;
            buf_valid_d = 1'b0;
            if (rd_word == p_q) begin
              din_d   = buf_q;
              p_d     = p_q + MEM_AW'(1);
              addr_d  = p_q + MEM_AW'(1);
              state_d = ST_PREFETCH;
            end else begin
              addr_d  = rd_word;
              state_d = ST_DEMAND;
            end
          end
        end

        ST_DEMAND: begin
          // The prefetch of the following word goes out back-to-back; the
          // HPS keeps waiting until that word is buffered.
          if (fetch_done) begin
            din_d   = fetch_data;
            if (timeout_hit) err_d = 1'b1;
            p_d     = addr_q + MEM_AW'(1);
            addr_d  = addr_q + MEM_AW'(1);
            req_d   = 1'b1;
            state_d = ST_PREFETCH;
          end
        end

        ST_DRAIN: begin
          // Drained data is dropped and a drain timeout is not an error.
          restart_d = restart_now;
          wait_d    = restart_now;
          if (fetch_done) begin
            restart_d = 1'b0;
            if (restart_now) begin
              state_d     = ST_PREFETCH;
              p_d         = '0;
              addr_d      = '0;
              req_d       = 1'b1;
              wait_d      = 1'b1;
              err_d       = 1'b0;
              buf_valid_d = 1'b0;
            end else begin
              req_d   = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          wait_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      din_q         <= '0;
      wait_q        <= 1'b0;
      req_q         <= 1'b0;
      addr_q        <= '0;
      err_q         <= 1'b0;
      buf_q         <= '0;
      buf_valid_q   <= 1'b0;
      p_q           <= '0;
      cnt_q         <= '0;
      restart_q     <= 1'b0;
      upload_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      din_q         <= din_d;
      wait_q        <= wait_d;
      req_q         <= req_d;
      addr_q        <= addr_d;
      err_q         <= err_d;
      buf_q         <= buf_d;
      buf_valid_q   <= buf_valid_d;
      p_q           <= p_d;
      cnt_q         <= cnt_d;
      restart_q     <= restart_d;
      upload_prev_q <= ioctl_upload;
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign mem_req    = req_q;
  assign mem_addr   = addr_q;
  assign upload_err = err_q;

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// tb_ioctl_upload_reader
// ---------------------------------------------------------------------------
// Bench for ioctl_upload_reader. A memory responder acks each request after a
// programmable number of cycles with word(a) = 16'hA500 + a. Expected read
// data and the next prefetch address come from the rule "reading word a
// returns word(a) and leaves the prefetch pointing at a+1 (mod 2^23)".
// ---------------------------------------------------------------------------
module tb_ioctl_upload_reader;
  localparam int AW = 23;
  localparam int TO = 255;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          ioctl_upload;
  logic          ioctl_rd;
  logic [24:0]   ioctl_addr;
  logic [15:0]   ioctl_din;
  logic          ioctl_wait;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [15:0]   mem_rdata;
  logic          upload_err;

  always #5 clk_sys = ~clk_sys;

  ioctl_upload_reader #(
    .MEM_AW    (AW),
    .TIMEOUT   (TO),
    .FILL_WORD (16'hFFFF)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ioctl_upload (ioctl_upload),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .upload_err   (upload_err)
  );

  int            n_checks = 0;
  int            n_pass   = 0;
  int            lat      = 3;
  bit            ack_en   = 1'b1;
  bit            busy     = 1'b0;
  int            wcnt     = 0;
  logic [AW-1:0] req_log[$];
  logic [AW-1:0] model_p;

  function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
    return 16'hA500 + a[15:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock; afterwards the responder decides this cycle's ack.
  task automatic tick();
    @(posedge clk_sys);
    #1;
    mem_ack   = 1'b0;
    mem_rdata = 16'($urandom);
    if (!mem_req) begin
      busy = 1'b0;
    end else begin
      if (!busy) begin
        busy = 1'b1;
        wcnt = 0;
        req_log.push_back(mem_addr);
      end
      if (ack_en && wcnt == lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
        busy      = 1'b0;
      end else begin
        wcnt++;
      end
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (ioctl_wait && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_wait_bound"}, ioctl_wait, 0);
  endtask

  task automatic hps_read(input string tag, input logic [AW-1:0] w, input logic [15:0] exp);
    bit hit;
    hit = (w == model_p);
    wait_ready(tag);
    ioctl_addr = {1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1))};
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd   = 1'b0;
    check({tag, "_wait_hi"}, ioctl_wait, 1);
    if (hit) check({tag, "_din_hit"}, ioctl_din, exp);
    else     check({tag, "_miss_addr"}, mem_addr, w);
    model_p = w + AW'(1);
    wait_ready(tag);
    check({tag, "_din"}, ioctl_din, exp);
    check({tag, "_next_addr"}, mem_addr, model_p);
    $display("read %s word %h hit %0d din %h", tag, w, hit, ioctl_din);
  endtask

  task automatic start_session(input string tag);
    ioctl_upload = 1'b1;
    tick();
    check({tag, "_req"}, mem_req, 1);
    check({tag, "_addr0"}, mem_addr, 0);
    check({tag, "_wait"}, ioctl_wait, 1);
    check({tag, "_err_clr"}, upload_err, 0);
    model_p = '0;
  endtask

  task automatic end_session(input string tag);
    int n;
    ioctl_upload = 1'b0;
    tick();
    check({tag, "_wait_lo"}, ioctl_wait, 0);
    n = 0;
    while (mem_req && n < 1000) begin
      tick();
      n++;
    end
    check({tag, "_req_lo"}, mem_req, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset        = 1'b1;
    ioctl_upload = 1'b0;
    ioctl_rd     = 1'b0;
    ioctl_addr   = '0;
    mem_ack      = 1'b0;
    mem_rdata    = '0;
    #1;
    check("reset_outs", {ioctl_din, ioctl_wait, mem_req, mem_addr, upload_err}, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_outs", {ioctl_din, ioctl_wait, mem_req, mem_addr, upload_err}, 0);

    // Sequential reads with 3-cycle ack latency.
    lat = 3;
    req_log.delete();
    start_session("seq_start");
    for (int i = 0; i < 4; i++)
      hps_read($sformatf("seq%0d", i), AW'(i), mem_word(AW'(i)));
    check("seq_nreq", req_log.size(), 5);
    for (int i = 0; i < 5 && i < req_log.size(); i++)
      check($sformatf("seq_req%0d", i), req_log[i], i);
    check("seq_err", upload_err, 0);

    // Miss after word 0 is buffered.
    end_session("seq_end");
    start_session("miss_start");
    hps_read("miss", AW'(23'h80), 16'hA580);

    // Strobe during ioctl_wait is ignored.
    lat = 6;
    wait_ready("viol");
    ioctl_addr = {1'b0, AW'(23'h81), 1'b0};
    ioctl_rd   = 1'b1;
    tick();
    ioctl_addr = {1'b0, AW'(23'h10), 1'b0};
    tick();
    ioctl_rd   = 1'b0;
    wait_ready("viol_done");
    check("viol_din", ioctl_din, mem_word(AW'(23'h81)));
    check("viol_addr", mem_addr, 23'h82);
    model_p = AW'(23'h82);
    hps_read("viol_next", AW'(23'h82), mem_word(AW'(23'h82)));

    // Address wrap at the top word.
    lat = 2;
    hps_read("wrap", AW'(23'h7FFFFF), mem_word(AW'(23'h7FFFFF)));
    hps_read("wrap_hit", AW'(0), mem_word(AW'(0)));

    // Timeout: memory never acks.
    end_session("wrap_end");
    ack_en = 1'b0;
    start_session("to_start");
    n = 0;
    while (mem_req && n < 1000) begin
      tick();
      n++;
    end
    check("to_req_cycles", n, TO);
    check("to_wait", ioctl_wait, 0);
    check("to_err", upload_err, 1);
    ack_en = 1'b1;
    hps_read("to_fill", AW'(0), 16'hFFFF);
    check("to_err_sticky", upload_err, 1);
    end_session("to_end");
    start_session("to_restart");

    // Ack in exactly the timeout cycle.
    end_session("to_restart_end");
    lat = TO - 1;
    start_session("race_start");
    wait_ready("race");
    check("race_err", upload_err, 0);
    lat = 2;
    hps_read("race_read", AW'(0), mem_word(AW'(0)));
    check("race_err2", upload_err, 0);

    // Upload drops while a prefetch is outstanding.
    hps_read("abort_pre", AW'(1), mem_word(AW'(1)));
    lat = 6;
    wait_ready("abort");
    ioctl_addr = {1'b0, AW'(2), 1'b0};
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd   = 1'b0;
    check("abort_din_hit", ioctl_din, mem_word(AW'(2)));
    ioctl_upload = 1'b0;
    tick();
    check("abort_wait_lo", ioctl_wait, 0);
    check("abort_req_held", mem_req, 1);
    n = 0;
    while (mem_req && n < 100) begin
      n++;
      tick();
    end
    check("abort_drain_cycles", n, lat);
    check("abort_din_kept", ioctl_din, mem_word(AW'(2)));
    check("abort_err", upload_err, 0);
    ioctl_addr = '0;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd   = 1'b0;
    check("idle_rd_ignored", {mem_req, ioctl_wait}, 0);

    // Upload restarts while the drain is still running.
    lat = 8;
    req_log.delete();
    start_session("rs_start");
    tick();
    ioctl_upload = 1'b0;
    tick();
    ioctl_upload = 1'b1;
    tick();
    check("rs_wait", ioctl_wait, 1);
    wait_ready("rs");
    check("rs_nreq", req_log.size(), 2);
    if (req_log.size() == 2) check("rs_addr", req_log[1], 0);
    model_p = '0;
    lat = 1;
    hps_read("rs_read", AW'(0), mem_word(AW'(0)));

    // Randomized mix of sequential and random reads.
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] w;
      lat = $urandom_range(0, 6);
      if ($urandom_range(0, 9) < 7) w = model_p;
      else                          w = AW'($urandom);
      hps_read($sformatf("rnd%0d", i), w, mem_word(w));
    end

    // Asynchronous reset in the middle of a prefetch.
    lat = 20;
    wait_ready("ar");
    ioctl_addr = {1'b0, model_p, 1'b0};
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd   = 1'b0;
    check("ar_req_before", mem_req, 1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_outs_zero", {ioctl_din, ioctl_wait, mem_req, mem_addr, upload_err}, 0);
    ioctl_upload = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("ar_outs_after", {ioctl_din, ioctl_wait, mem_req, mem_addr, upload_err}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
